// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, with the key schedule expanded on the fly.
// Define AES_TRIGGER_EN to drive trig_o across the run; when undefined, trig_o is tied to 0.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = SBOX[a];
endmodule

// One full cipher round, including the expansion of the round key it consumes.
module aes_round (
  input  logic [127:0] s_i,
  input  logic [127:0] k_i,
  input  logic [7:0]   rc_i,
  input  logic         last_i,
  output logic [127:0] s_o,
  output logic [127:0] k_o,
  output logic [7:0]   rc_o
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [31:0]  rot, sw, n0, n1, n2, n3;
  logic [127:0] sb, sr, mc;

  assign rot = {k_i[23:0], k_i[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sbox (.a(rot[31-8*j -: 8]), .y(sw[31-8*j -: 8]));
  end
  assign n0   = k_i[127:96] ^ sw ^ {rc_i, 24'h0};
  assign n1   = k_i[95:64] ^ n0;
  assign n2   = k_i[63:32] ^ n1;
  assign n3   = k_i[31:0]  ^ n2;
  assign k_o  = {n0, n1, n2, n3};
  assign rc_o = xt(rc_i);

  for (genvar b = 0; b < 16; b++) begin : g_dsb
    aes_sbox u_sbox (.a(s_i[127-8*b -: 8]), .y(sb[127-8*b -: 8]));
  end

  // Byte 4c+r holds row r of column c; row r rotates left by r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  assign s_o = (last_i ? sr : mc) ^ k_o;
endmodule

module aes128_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   round_o,
  output logic         trig_o
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, data_q, data_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         load_acc, fin;

  logic [127:0] s_ch  [UNROLL+1];
  logic [127:0] k_ch  [UNROLL+1];
  logic [7:0]   rc_ch [UNROLL+1];

  assign s_ch[0]  = st_q;
  assign k_ch[0]  = rk_q;
  assign rc_ch[0] = rcon_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    localparam logic [4:0] OFS = 5'(i + 1);
    logic last;
    assign last = (({1'b0, round_q} + OFS) == 5'd10);
    aes_round u_round (
      .s_i(s_ch[i]), .k_i(k_ch[i]), .rc_i(rc_ch[i]), .last_i(last),
      .s_o(s_ch[i+1]), .k_o(k_ch[i+1]), .rc_o(rc_ch[i+1]));
  end

  assign load_acc = (state_q == IDLE) && load_i;
  assign fin      = (state_q == RUN) && ((round_q + 4'(UNROLL)) == 4'd10);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (load_acc) begin
        st_d    = data_i ^ key_i;
        rk_d    = key_i;
        rcon_d  = 8'h01;
        round_d = 4'd0;
        state_d = RUN;
      end
      RUN: begin
        st_d    = s_ch[UNROLL];
        rk_d    = k_ch[UNROLL];
        rcon_d  = rc_ch[UNROLL];
        round_d = round_q + 4'(UNROLL);
        if (fin) begin
          data_d  = s_ch[UNROLL];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rcon_q  <= 8'h01;
      round_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

`ifdef AES_TRIGGER_EN
  logic trig_q, trig_d;
  always_comb begin
    trig_d = trig_q;
    if (load_acc)  trig_d = 1'b1;
    else if (fin)  trig_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= trig_d;
  end
  assign trig_o = trig_q;
`else
  assign trig_o = 1'b0;
`endif

  assign data_o  = data_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
  assign round_o = round_q;
endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: FIPS-197 vector table, random blocks against a byte-level
// reference model, and hand-written handshake corner cases.
module tb_aes128_iter_core;
  localparam int UNROLL = 1;
  localparam int LAT    = 10 / UNROLL;
`ifdef AES_TRIGGER_EN
  localparam logic TRIG = 1'b1;
`else
  localparam logic TRIG = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, load_i = 1'b0;
  logic [127:0] key_i = '0, data_i = '0, data_o;
  logic         busy_o, done_o, trig_o;
  logic [3:0]   round_o;

  int n_chk = 0, n_fail = 0;
  logic [7:0] sbx [256];

  aes128_iter_core #(.UNROLL(UNROLL)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .key_i(key_i), .data_i(data_i),
    .data_o(data_o), .busy_o(busy_o), .done_o(done_o), .round_o(round_o), .trig_o(trig_o));

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model in GF(2^8) arithmetic, independent of any lookup table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tw;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbx[tw[23:16]], sbx[tw[15:8]], sbx[tw[7:0]], sbx[tw[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ key[127-8*b -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = sbx[s[4*((c+j)%4)+j]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
          s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
        end
        for (int j = 0; j < 4; j++) s[4*c+j] ^= w[4*r+c][31-8*j -: 8];
      end
    end
    for (int b = 0; b < 16; b++) out[127-8*b -: 8] = s[b];
    return out;
  endfunction

  // Load pulse; returns at the negedge right after the load edge, with inputs scrambled.
  task automatic do_load(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    key_i = k; data_i = p; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0; key_i = ~k; data_i = ~p;
  endtask

  // cyc counts edges since the load edge; checks the busy/trig/round trajectory until done.
  task automatic wait_done(input int cyc0, input logic [127:0] exp, input string nm,
                           input bit chk_pulse);
    int cyc = cyc0;
    int bad = 0;
    while (!done_o && cyc < 40) begin
      if (busy_o !== 1'b1 || trig_o !== TRIG || round_o !== 4'(cyc * UNROLL)) bad++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " window"}, 128'(bad), 128'd0);
    chk({nm, " latency"}, 128'(cyc), 128'(LAT));
    chk({nm, " data_o"}, data_o, exp);
    chk({nm, " end_status"}, {busy_o, trig_o, round_o}, {1'b0, 1'b0, 4'd10});
    if (chk_pulse) begin
      @(negedge clk);
      chk({nm, " done_pulse"}, {done_o, round_o, data_o}, {1'b0, 4'd10, exp});
    end
  endtask

  initial begin
    vec_t tbl[3];
    logic [127:0] k, p;
    int nd;
    tbl[0] = '{"fips_c1", K1, P1, C1};
    tbl[1] = '{"fips_b",  K2, P2, C2};
    tbl[2] = '{"zero",    128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    build_sbox();

    #12;
    chk("reset_outputs", {data_o, busy_o, done_o, trig_o, round_o}, '0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_load(tbl[i].key, tbl[i].pt);
      wait_done(0, tbl[i].ct, tbl[i].name, 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      do_load(k, p);
      wait_done(0, model(k, p), "random", 1'b1);
    end

    // Load while busy is ignored; only one done pulse.
    do_load(K1, P1);
    repeat (3) @(negedge clk);
    key_i = K2; data_i = P2; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    wait_done(4, C1, "load_busy", 1'b0);
    nd = 0;
    repeat (15) begin @(negedge clk); if (done_o) nd++; end
    chk("load_busy extra_done", 128'(nd), 128'd0);
    chk("load_busy idle", {busy_o, data_o}, {1'b0, C1});

    // Back-to-back: load in the done cycle; first result held until the second completes.
    do_load(K1, P1);
    wait_done(0, C1, "b2b_first", 1'b0);
    key_i = K2; data_i = P2; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    chk("b2b accepted", {busy_o, done_o, data_o}, {1'b1, 1'b0, C1});
    wait_done(0, C2, "b2b_second", 1'b1);

    // Asynchronous abort mid-run.
    do_load(K1, P1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort outputs", {data_o, busy_o, done_o, trig_o, round_o}, '0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (12) begin @(negedge clk); if (done_o || busy_o) nd++; end
    chk("abort quiet", 128'(nd), 128'd0);
    do_load(K1, P1);
    wait_done(0, C1, "after_abort", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
